demux_sched: RTL and testbench
==============================

# demux_sched

Scheduler that sequences the 1-to-4 demultiplexer. It accepts tagged words from a single valid/ready source and drives the demux `sel`. It presents each word to the addressed sink, or to all four sinks for a broadcast, through per-sink valid/ready handshakes. It sits between the upstream producer and the `demux_4x1` datapath, holding one word in flight.

## Interface
Parameters:
- `DW`, 8, data width.
- `TIMEOUT`, 16, maximum stall cycles per word before drop (timeout build only; ≥2).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `in_valid`  in  1  source word valid.
- `in_ready`  out  1  scheduler can accept a word.
- `in_data`  in  DW  source word.
- `in_dest`  in  2  destination index 0..3.
- `in_bcast`  in  1  deliver to all four sinks; `in_dest` is ignored.
- `out_valid`  out  4  per-sink valid.
- `out_ready`  in  4  per-sink ready.
- `out_data`  out  DW  held word, common to all sinks.
- `sel`  out  2  demux select.
- `busy`  out  1  a word is held.
- `err`  out  1  one-cycle pulse when a word is dropped on timeout.

## Operation
- **States:**
  - IDLE: no word held.
  - SEND: a word is held and has one or more pending sinks.
- **Pending mask `pend[3:0]`:**
  - On capture, `pend` = `4'hF` if `in_bcast`, else one-hot(`in_dest`).
  - `out_valid` = `pend` when in SEND; otherwise `4'h0`.
- **`in_ready`:**
  - 0 while `rst_n`=0.
  - Otherwise 1 in IDLE.
  - In SEND, 1 only when `pend & out_ready == pend` (the final acceptance happens this cycle).
  - This gives back-to-back throughput of one word per cycle for unicast.
- **IDLE transitions:**
  - IDLE → SEND when `in_valid`; capture `in_data`, `pend` and the destination.
- **SEND transitions, each cycle:**
  - Clear `pend` bits where `out_valid & out_ready`.
  - If `pend` becomes 0 and `in_valid`=1, capture the next word and stay in SEND.
  - If `pend` becomes 0 and `in_valid`=0, go to IDLE.
- **`sel`:**
  - In SEND, `sel` = index of the lowest set bit of `pend`.
  - In IDLE, `sel` holds its last value.
- **Broadcast:**
  - Sinks may accept in any order or all in one cycle.
  - A sink that has accepted sees its `out_valid` drop the next cycle.
- **`out_data`:** held stable for the whole SEND period of a word.
- **`busy`** = (state == SEND).

## Timing
- **Reset values:**
  - state IDLE, `pend`=0, `out_valid`=0, `sel`=2'b00, `out_data`=0, `busy`=0, `err`=0.
  - Stall counter = 0, `in_ready`=0.
- **Latency:** a word captured at edge N has `out_valid` high in cycle N+1. Minimum unicast latency is 1 cycle.
- **Simultaneous capture and completion:** completion and next capture occur on the same edge. `pend` is loaded from the new word; there is no bubble.
- **`out_ready` to non-pending sinks:** ignored.
- **`in_valid` while `in_ready`=0:** the source must hold its word; the scheduler does not capture.
- **Reset mid-SEND:** the held word is discarded with no `err` pulse, and all outputs return to reset values on the next edge.

## Configuration
- **`DEMUX_SCHED_TIMEOUT_EN` defined:**
  - An 8-bit stall counter clears on capture and on any acceptance.
  - It increments on each SEND cycle with no acceptance.
  - When it reaches `TIMEOUT`-1 with no acceptance that cycle, the word is dropped on the next edge: `pend`←0, state→IDLE, `err`=1 for one cycle.
  - A new word is not captured on that edge.
- **Not defined:** SEND waits indefinitely, no counter is instantiated, and `err` is tied 0.

## Structure
- **Package `demux_pkg`:** state encoding (`ST_IDLE`=0, `ST_SEND`=1), sink count constant `N_SINK`=4, and default `DW`.
- **Sub-module `demux_sched_prio4`:** combinational lowest-set-bit encoder from `pend` to `sel`.
- **Top level:** instantiates `demux_sched` alongside `demux_4x1`, with `sel` wired directly.

## Test plan
- Reset asserted 3 cycles → `out_valid`=0, `sel`=0, `in_ready`=0, `busy`=0; after release `in_ready`=1.
- Unicast `in_data`=8'hA5, `in_dest`=2, `out_ready`=4'hF → next cycle `out_valid`=4'b0100, `sel`=2, `out_data`=8'hA5; done in 1 cycle.
- Four back-to-back unicasts to dest 0,1,2,3 with all sinks ready → `out_valid` walks 0001, 0010, 0100, 1000 on consecutive cycles and `in_ready` stays 1.
- Broadcast 8'h3C:
  - `out_ready`=0001, then 0100, then 1010 → `pend` goes 1110, 1010, 0000.
  - `sel` goes 1, 1, then IDLE.
  - `in_ready` is high only in the third cycle.
- Unicast to dest 1 with `out_ready[1]`=0 held for 5 cycles, then 1 → word held stable, `sel`=1 throughout, delivered in cycle 6.
- With `DEMUX_SCHED_TIMEOUT_EN`, `TIMEOUT`=4, `out_ready`=0 → `err` pulses once after 4 SEND cycles, returns to IDLE, and the next word is delivered normally.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared state encoding and sizing for the demux scheduler.
// Revision : 1.0
// ============================================================================
package demux_pkg;

    localparam int N_SINK     = 4;
    localparam int DW_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/demux_sched_prio4.sv
`default_nettype none
// ============================================================================
// Module   : demux_sched_prio4
// Brief    : Lowest-set-bit encoder turning the pending mask into a select.
// Revision : 1.0
// ============================================================================
module demux_sched_prio4
    import demux_pkg::*;
(
    input  logic [N_SINK-1:0] pend,
    output logic [1:0]        sel
);

    always_comb begin
        sel = 2'd0;
        if (pend[0])      sel = 2'd0;
        else if (pend[1]) sel = 2'd1;
        else if (pend[2]) sel = 2'd2;
        else if (pend[3]) sel = 2'd3;
    end

endmodule
`default_nettype wire

// File: rtl/demux_sched.sv
`default_nettype none
// ============================================================================
// Module   : demux_sched
// Brief    : One-word-in-flight scheduler for a 1-to-4 demux with unicast and
//            broadcast delivery. Optional stall timeout: DEMUX_SCHED_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module demux_sched
    import demux_pkg::*;
#(
    parameter int DW = DW_DEFAULT
`ifdef DEMUX_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [1:0]        in_dest,
    input  logic              in_bcast,
    output logic [N_SINK-1:0] out_valid,
    input  logic [N_SINK-1:0] out_ready,
    output logic [DW-1:0]     out_data,
    output logic [1:0]        sel,
    output logic              busy,
    output logic              err
);

    state_t              r_state;
    logic [N_SINK-1:0]   r_pend;
    logic [DW-1:0]       r_data;
    logic [1:0]          r_sel;

    logic [N_SINK-1:0]   w_acc;
    logic                w_done;
    logic                w_cap;
    logic                w_drop;
    logic [N_SINK-1:0]   w_pend_new;
    logic [N_SINK-1:0]   w_pend_nxt;
    logic [1:0]          w_sel_nxt;

    assign w_acc  = r_pend & out_ready;
    assign w_done = (r_state == ST_SEND) && (w_acc == r_pend);

    // Accepting while the last pending sink completes removes the bubble.
    assign in_ready = rst_n & ((r_state == ST_IDLE) | w_done);
    assign w_cap    = in_valid & in_ready;

    assign w_pend_new = in_bcast ? {N_SINK{1'b1}} : (N_SINK'(1) << in_dest);

    always_comb begin
        w_pend_nxt = r_pend & ~out_ready;
        if (w_cap)
            w_pend_nxt = w_pend_new;
        else if (w_drop)
            w_pend_nxt = '0;
    end

    demux_sched_prio4 u_prio (
        .pend (w_pend_nxt),
        .sel  (w_sel_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_data  <= '0;
            r_sel   <= 2'd0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_state <= (w_pend_nxt != '0) ? ST_SEND : ST_IDLE;
            if (w_cap)
                r_data <= in_data;
            // Select only follows a live mask so it holds its value in IDLE.
            if (w_pend_nxt != '0)
                r_sel <= w_sel_nxt;
        end
    end

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    assign w_drop = (r_state == ST_SEND) && (w_acc == '0) && (r_cnt == c_tmo_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_drop;
            if (w_cap || (w_acc != '0) || w_drop)
                r_cnt <= 8'd0;
            else if (r_state == ST_SEND)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign err = r_err;
`else
    assign w_drop = 1'b0;
    assign err    = 1'b0;
`endif

    assign out_valid = (r_state == ST_SEND) ? r_pend : '0;
    assign out_data  = r_data;
    assign sel       = r_sel;
    assign busy      = (r_state == ST_SEND);

endmodule
`default_nettype wire

// File: tb/tb_demux_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_sched
// Brief    : Randomized bench for demux_sched against a word-level model.
// Revision : 1.0
// ============================================================================
module tb_demux_sched;

    localparam int DW = 8;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam int TMO = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          in_bcast;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    sel;
    logic          busy;
    logic          err;

`ifdef DEMUX_SCHED_TIMEOUT_EN
    demux_sched #(.DW(DW), .TIMEOUT(TMO)) dut (
`else
    demux_sched #(.DW(DW)) dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Word-level model: the held word and which sinks still owe an acceptance.
    bit          m_busy;
    logic [7:0]  m_data;
    bit          m_left [4];
    logic [1:0]  m_sel;
    bit          m_err;
    int          m_stall;
    bit          m_last_take;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_mask();
        logic [3:0] m = 4'h0;
        for (int k = 0; k < 4; k++) if (m_busy && m_left[k]) m[k] = 1'b1;
        return m;
    endfunction

    function automatic bit m_ready_exp();
        if (!rst_n) return 1'b0;
        if (!m_busy) return 1'b1;
        for (int k = 0; k < 4; k++) if (m_left[k] && !out_ready[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_data = '0; m_sel = 2'd0; m_err = 0; m_stall = 0; m_last_take = 0;
        for (int k = 0; k < 4; k++) m_left[k] = 0;
    endtask

    task automatic model_edge();
        bit take;
        bit any_acc;
        bit any_left;
        if (!rst_n) begin
            model_reset();
            return;
        end
        take    = m_ready_exp() && in_valid;
        any_acc = 0;
        m_err   = 0;
        if (m_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (m_left[k] && out_ready[k]) begin
                    m_left[k] = 0;
                    any_acc = 1;
                end
            end
            any_left = 0;
            for (int k = 0; k < 4; k++) if (m_left[k]) any_left = 1;
            if (!any_left) begin
                m_busy = 0;
            end else if (any_acc) begin
                m_stall = 0;
            end else begin
                m_stall++;
`ifdef DEMUX_SCHED_TIMEOUT_EN
                if (m_stall == TMO) begin
                    for (int k = 0; k < 4; k++) m_left[k] = 0;
                    m_busy  = 0;
                    m_err   = 1;
                    m_stall = 0;
                end
`endif
            end
        end
        if (take) begin
            m_busy  = 1;
            m_data  = in_data;
            m_stall = 0;
            for (int k = 0; k < 4; k++) m_left[k] = in_bcast || (in_dest == 2'(k));
        end
        if (m_busy) begin
            for (int k = 3; k >= 0; k--) if (m_left[k]) m_sel = 2'(k);
        end
        m_last_take = take;
    endtask

    task automatic check_all();
        chk("in_ready",  {31'd0, in_ready}, {31'd0, m_ready_exp()});
        chk("out_valid", {28'd0, out_valid}, {28'd0, m_mask()});
        chk("busy",      {31'd0, busy},     {31'd0, m_busy});
        chk("err",       {31'd0, err},      {31'd0, m_err});
        chk("sel",       {30'd0, sel},      {30'd0, m_sel});
        chk("out_data",  {24'd0, out_data}, {24'd0, m_data});
    endtask

    // Inputs are set at the falling edge; outputs checked 1 ns later.
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic put(input logic v, input logic [7:0] d, input logic [1:0] dst, input logic b);
        in_valid = v; in_data = d; in_dest = dst; in_bcast = b;
    endtask

    int stall_len;

    initial begin
        model_reset();
        rst_n = 1'b0; put(0, 8'h00, 2'd0, 0); out_ready = 4'h0;
        @(negedge clk);

        repeat (3) cycle();
        #1;
        chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
        chk("rst_sel",       {30'd0, sel},       32'h0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'h0);
        chk("rst_busy",      {31'd0, busy},      32'h0);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'h1);
        @(negedge clk);

        // Single unicast
        out_ready = 4'hF; put(1, 8'hA5, 2'd2, 0);
        cycle();
        put(0, 8'h00, 2'd0, 0);
        #1;
        chk("uni_out_valid", {28'd0, out_valid}, 32'h4);
        chk("uni_sel",       {30'd0, sel},       32'h2);
        chk("uni_out_data",  {24'd0, out_data},  32'hA5);
        cycle();
        chk("uni_done_busy", {31'd0, busy}, 32'h0);

        // Back-to-back unicasts
        for (int d = 0; d < 4; d++) begin
            put(1, 8'(8'h10 + d), 2'(d), 0);
            cycle();
            chk("b2b_out_valid", {28'd0, out_valid}, 32'h1 << d);
            #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'h1);
            @(negedge clk);
        end
        put(0, 8'h00, 2'd0, 0);
        cycle();

        // Broadcast with staggered acceptance
        out_ready = 4'h0; put(1, 8'h3C, 2'd3, 1);
        cycle();
        put(0, 8'h00, 2'd0, 0);
        out_ready = 4'b0001;
        #1 chk("bc_rdy1", {31'd0, in_ready}, 32'h0);
        cycle();
        chk("bc_pend1", {28'd0, out_valid}, 32'hE);
        chk("bc_sel1",  {30'd0, sel},       32'h1);
        out_ready = 4'b0100;
        #1 chk("bc_rdy2", {31'd0, in_ready}, 32'h0);
        cycle();
        chk("bc_pend2", {28'd0, out_valid}, 32'hA);
        chk("bc_sel2",  {30'd0, sel},       32'h1);
        out_ready = 4'b1010;
        #1 chk("bc_rdy3", {31'd0, in_ready}, 32'h1);
        cycle();
        chk("bc_pend3", {28'd0, out_valid}, 32'h0);
        chk("bc_idle_sel", {30'd0, sel},    32'h1);

        // Stalled unicast to sink 1
`ifdef DEMUX_SCHED_TIMEOUT_EN
        stall_len = TMO - 2;
`else
        stall_len = 5;
`endif
        out_ready = 4'b1101; put(1, 8'h5A, 2'd1, 0);
        cycle();
        put(0, 8'h00, 2'd0, 0);
        for (int i = 0; i < stall_len; i++) begin
            cycle();
            chk("stall_data", {24'd0, out_data},  32'h5A);
            chk("stall_sel",  {30'd0, sel},       32'h1);
            chk("stall_vld",  {28'd0, out_valid}, 32'h2);
        end
        out_ready = 4'b0010;
        cycle();
        chk("stall_done", {31'd0, busy}, 32'h0);

`ifdef DEMUX_SCHED_TIMEOUT_EN
        out_ready = 4'h0; put(1, 8'h77, 2'd3, 0);
        cycle();
        put(0, 8'h00, 2'd0, 0);
        for (int i = 0; i < TMO - 1; i++) begin
            cycle();
            chk("tmo_no_err", {31'd0, err}, 32'h0);
        end
        cycle();
        chk("tmo_err",  {31'd0, err},  32'h1);
        chk("tmo_idle", {31'd0, busy}, 32'h0);
        out_ready = 4'hF; put(1, 8'h99, 2'd0, 0);
        cycle();
        put(0, 8'h00, 2'd0, 0);
        chk("tmo_err_clr", {31'd0, err},       32'h0);
        chk("tmo_next",    {28'd0, out_valid}, 32'h1);
        chk("tmo_data",    {24'd0, out_data},  32'h99);
        cycle();
`endif

        // Randomized traffic; the source holds a refused word.
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !m_last_take && rst_n)) begin
                put(($urandom % 4) != 0, 8'($urandom), 2'($urandom), ($urandom % 5) == 0);
            end
            if (($urandom % 4) == 0) out_ready = 4'h0;
            else for (int k = 0; k < 4; k++) out_ready[k] = ($urandom % 10) < 6;
            rst_n = ($urandom % 100) != 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
